// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0
    localparam int unsigned REG_W     = 5;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             wr;
        logic             ld;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

    // True when a valid producer entry writes a register the ID instruction reads.
    function automatic logic src_match(
        input sb_entry_t        e,
        input logic             use_rs1,
        input logic [REG_W-1:0] rs1,
        input logic             use_rs2,
        input logic [REG_W-1:0] rs2
    );
        return e.wr && (e.rd != '0) &&
               ((use_rs1 && (rs1 == e.rd)) || (use_rs2 && (rs2 == e.rd)));
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow copy of the destination fields in EX, MEM and WB plus the RAW compare
// against the instruction currently in ID.
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_advance,
    input  logic             i_load_id,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_use_rs1,
    input  logic             i_use_rs2,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_wr,
    input  logic             i_ld,
    output logic             o_match_ex,
    output logic             o_ld_ex,
    output logic             o_match_mem,
    output logic             o_match_wb
);

    sb_entry_t r_ex;
    sb_entry_t r_mem;
    sb_entry_t r_wb;
    sb_entry_t w_ex_next;

    // Entry entering EX: the ID instruction or a bubble.
    always_comb begin
        w_ex_next = SB_BUBBLE;
        if (i_load_id) begin
            w_ex_next = '{rd: i_rd, wr: i_wr, ld: i_ld};
        end
    end

    // Shift the shadow entries along with the pipe; hold while frozen.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ex  <= SB_BUBBLE;
            r_mem <= SB_BUBBLE;
            r_wb  <= SB_BUBBLE;
        end else if (i_advance) begin
            r_ex  <= w_ex_next;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // Per-stage RAW compare, gated by a real instruction in ID.
    always_comb begin
        o_match_ex  = i_id_valid && src_match(r_ex,  i_use_rs1, i_rs1, i_use_rs2, i_rs2);
        o_match_mem = i_id_valid && src_match(r_mem, i_use_rs1, i_rs1, i_use_rs2, i_rs2);
        o_match_wb  = i_id_valid && src_match(r_wb,  i_use_rs1, i_rs1, i_use_rs2, i_rs2);
        o_ld_ex     = r_ex.ld;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for IF, IF/ID, ID/EX and EX/MEM,
// RAW stalls, branch redirect, data-memory freeze and a stall-cycle counter.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             ID_VALID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             USE_RS1_ID,
    input  logic             USE_RS2_ID,
    input  logic [4:0]       RD_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic             BR_TAKEN_EX,
    input  logic             DMEM_REQ,
    input  logic             DMEM_READY,
    output logic             PC_EN,
    output logic             PC_SEL,
    output logic             FD_EN,
    output logic             FD_FLUSH,
    output logic             IDEX_FLUSH,
    output logic             EXMEM_EN,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_freeze;
    logic             w_data_stall;
    logic             w_match_ex;
    logic             w_ld_ex;
    logic             w_match_mem;
    logic             w_match_wb;

    hazard_scoreboard u_sb (
        .i_clk      (CLK),
        .i_rstn     (RSTN),
        .i_advance  (!w_freeze),
        .i_load_id  (ID_VALID && !IDEX_FLUSH),
        .i_id_valid (ID_VALID),
        .i_rs1      (RS1_ID),
        .i_rs2      (RS2_ID),
        .i_use_rs1  (USE_RS1_ID),
        .i_use_rs2  (USE_RS2_ID),
        .i_rd       (RD_ID),
        .i_wr       (RegWrite_ID),
        .i_ld       (MemRead_ID),
        .o_match_ex (w_match_ex),
        .o_ld_ex    (w_ld_ex),
        .o_match_mem(w_match_mem),
        .o_match_wb (w_match_wb)
    );

    // Hazard detection: load-use only with forwarding, any in-flight producer without.
    always_comb begin
        w_freeze = DMEM_REQ && !DMEM_READY;
        if (FWD_EN) begin
            w_data_stall = w_match_ex && w_ld_ex;
        end else begin
            w_data_stall = w_match_ex || w_match_mem || w_match_wb;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: enter MEM_WAIT on an unfinished access, leave on READY.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (w_freeze)   w_state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (DMEM_READY) w_state_next = ST_RUN;
            default:                     w_state_next = ST_RUN;
        endcase
    end

    // Stage controls in priority order: reset, freeze, redirect, data stall, run.
    always_comb begin
        PC_EN      = 1'b1;
        PC_SEL     = 1'b0;
        FD_EN      = 1'b1;
        FD_FLUSH   = 1'b0;
        IDEX_FLUSH = 1'b0;
        EXMEM_EN   = 1'b1;
        if (!RSTN) begin
            PC_EN      = 1'b0;
            FD_EN      = 1'b0;
            FD_FLUSH   = 1'b1;
            IDEX_FLUSH = 1'b1;
            EXMEM_EN   = 1'b0;
        end else if (w_freeze) begin
            PC_EN      = 1'b0;
            FD_EN      = 1'b0;
            EXMEM_EN   = 1'b0;
        end else if (BR_TAKEN_EX) begin
            PC_SEL     = 1'b1;
            FD_FLUSH   = 1'b1;
            IDEX_FLUSH = 1'b1;
        end else if (w_data_stall) begin
            PC_EN      = 1'b0;
            FD_EN      = 1'b0;
            IDEX_FLUSH = 1'b1;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_stall_cnt <= '0;
        end else if (!PC_EN && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign STALL_CYCLES = r_stall_cnt;

endmodule
